// File: rtl/bus_trace_buffer_if.sv
// Signal bundle between the board top level and the bus trace buffer.
// Handshake: there is no valid/ready pair on this bundle; every input is a
// plain level sampled on each rising clock edge, and every output is a
// registered level that is stable for the whole cycle after the edge.
interface bus_trace_buffer_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] BusWires;
    logic             Capture;
    logic             Done;
    logic             Step;
    logic             Clear;
    logic [WIDTH-1:0] RdData;
    logic [AW-1:0]    RdIndex;
    logic [AW:0]      Count;
    logic             Frozen;
    logic             Overflow;
    logic [1:0]       TraceState;   // debug view of the FSM state register

    modport slave (
        input  BusWires, Capture, Done, Step, Clear,
        output RdData, RdIndex, Count, Frozen, Overflow, TraceState
    );

    modport master (
        output BusWires, Capture, Done, Step, Clear,
        input  RdData, RdIndex, Count, Frozen, Overflow, TraceState
    );
endinterface

// File: rtl/bus_trace_buffer.sv
// Circular trace of the processor bus. Records BusWires while an instruction
// runs, freezes on Done, and lets the user walk the captured words with a
// debounced push-button level (one advance per press).
module bus_trace_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    bus_trace_buffer_if.slave  bus
);
    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        RECORD = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    rd_index;
    logic [AW:0]      count;
    logic             overflow;
    logic             frozen;
    logic             step_q;
    logic [WIDTH-1:0] rd_data;

    logic             wr_en;
    logic             mem_we;
    logic             step_pulse;
    logic             full;
    logic             empty;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    // Address arithmetic wraps naturally in AW bits (DEPTH is a power of 2).
    // When full, count[AW-1:0] is zero, so the write lands on the oldest slot.
    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign wr_addr    = head + count[AW-1:0];
    assign rd_addr    = head + rd_index;
    assign step_pulse = bus.Step & ~step_q;
    // Clear and Reset discard any write presented in the same cycle.
    assign mem_we     = wr_en & ~Reset & ~bus.Clear;

    // Next-state and write-enable decode; Done only freezes, it never writes alone.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        case (state)
            ARMED: begin
                if (bus.Capture) begin
                    wr_en      = 1'b1;
                    state_next = bus.Done ? FROZEN : RECORD;
                end
            end
            RECORD: begin
                wr_en = bus.Capture;
                if (bus.Done) begin
                    state_next = FROZEN;
                end
            end
            FROZEN: begin
                state_next = FROZEN;
            end
            default: begin
                state_next = ARMED;
            end
        endcase
    end

    // Control registers: FSM, ring pointers, view index, step edge detect, read port.
    always_ff @(posedge Clock) begin
        if (Reset || bus.Clear) begin
            state    <= ARMED;
            head     <= '0;
            count    <= '0;
            rd_index <= '0;
            overflow <= 1'b0;
            frozen   <= 1'b0;
            step_q   <= 1'b0;
            rd_data  <= '0;
        end else begin
            state  <= state_next;
            frozen <= (state_next == FROZEN);
            step_q <= bus.Step;

            if (wr_en) begin
                if (full) begin
                    head     <= head + 1'b1;
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end

            // Wrap point uses the pre-edge count, even if a write lands this cycle.
            if (step_pulse && !empty) begin
                if ({1'b0, rd_index} == count - 1'b1) begin
                    rd_index <= '0;
                end else begin
                    rd_index <= rd_index + 1'b1;
                end
            end

            // Registered read of pre-edge contents; a same-address write shows next cycle.
            rd_data <= empty ? '0 : mem[rd_addr];
        end
    end

    // Trace storage; contents survive Reset/Clear and are masked by count.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[wr_addr] <= bus.BusWires;
        end
    end

    assign bus.RdData     = rd_data;
    assign bus.RdIndex    = rd_index;
    assign bus.Count      = count;
    assign bus.Frozen     = frozen;
    assign bus.Overflow   = overflow;
    assign bus.TraceState = state;
endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed bench for bus_trace_buffer: the driver issues vectors and queues the
// hand-computed expected outputs; a monitor on the falling edge checks them.
module tb_bus_trace_buffer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    localparam logic [31:0] ST_ARMED  = 32'd0;
    localparam logic [31:0] ST_RECORD = 32'd1;
    localparam logic [31:0] ST_FROZEN = 32'd2;

    typedef enum int {S_DATA, S_INDEX, S_COUNT, S_FROZEN, S_OVF, S_STATE} sel_t;

    typedef struct {
        sel_t        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_trace_buffer_if #(.WIDTH(WIDTH), .AW(AW)) bif ();

    bus_trace_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bif.slave)
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push_exp(input sel_t sel, input logic [31:0] val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] actual(input sel_t sel);
        case (sel)
            S_DATA:   return 32'(bif.RdData);
            S_INDEX:  return 32'(bif.RdIndex);
            S_COUNT:  return 32'(bif.Count);
            S_FROZEN: return 32'(bif.Frozen);
            S_OVF:    return 32'(bif.Overflow);
            S_STATE:  return 32'(bif.TraceState);
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: outputs are registered, so mid-cycle (falling edge) is stable.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual(e.sel);
            total++;
            if (a !== e.val) begin
                bad++;
                $display("FAIL %s: got 0x%0h want 0x%0h", e.name, a, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_once(input int idx, input logic [31:0] data, input string tag);
        bif.Step = 1'b1;
        tick();
        push_exp(S_INDEX, 32'(idx), {tag, "_idx"});
        bif.Step = 1'b0;
        tick();
        push_exp(S_DATA, data, {tag, "_data"});
    endtask

    task automatic check_cleared(input string tag);
        push_exp(S_COUNT,  32'd0,    {tag, "_count"});
        push_exp(S_INDEX,  32'd0,    {tag, "_idx"});
        push_exp(S_OVF,    32'd0,    {tag, "_ovf"});
        push_exp(S_FROZEN, 32'd0,    {tag, "_frozen"});
        push_exp(S_DATA,   32'd0,    {tag, "_data"});
        push_exp(S_STATE,  ST_ARMED, {tag, "_state"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        bif.BusWires = '0;
        bif.Capture  = 1'b0;
        bif.Done     = 1'b0;
        bif.Step     = 1'b0;
        bif.Clear    = 1'b0;

        // Reset state
        tick();
        check_cleared("reset");
        rst = 1'b0;

        // Short capture ending with Done on the third word
        bif.Capture = 1'b1; bif.BusWires = 16'h1111; tick();
        bif.BusWires = 16'h2222; tick();
        bif.BusWires = 16'h3333; bif.Done = 1'b1; tick();
        bif.Capture = 1'b0; bif.Done = 1'b0;
        push_exp(S_COUNT,  32'd3,      "cap3_count");
        push_exp(S_FROZEN, 32'd1,      "cap3_frozen");
        push_exp(S_STATE,  ST_FROZEN,  "cap3_state");
        push_exp(S_DATA,   32'h1111,   "cap3_data");
        step_once(1, 32'h2222, "cap3_step1");
        step_once(2, 32'h3333, "cap3_step2");
        step_once(0, 32'h1111, "cap3_wrap");

        // Frozen: capture attempts are ignored
        bif.BusWires = 16'hABCD; bif.Capture = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bif.Capture = 1'b0;
        tick();
        push_exp(S_COUNT,  32'd3,    "frz_count");
        push_exp(S_FROZEN, 32'd1,    "frz_frozen");
        push_exp(S_DATA,   32'h1111, "frz_data");

        // Held button advances exactly once
        bif.Step = 1'b1;
        tick();
        push_exp(S_INDEX, 32'd1, "hold_first");
        for (int i = 0; i < 19; i++) tick();
        push_exp(S_INDEX, 32'd1, "hold_last");
        bif.Step = 1'b0;
        tick();
        push_exp(S_DATA, 32'h2222, "hold_data");

        // Clear, then step on an empty trace
        bif.Clear = 1'b1; tick(); bif.Clear = 1'b0;
        check_cleared("clr1");
        step_once(0, 32'h0, "empty_step");

        // Overflow: ten words into eight slots
        bif.Capture = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bif.BusWires = 16'(i);
            tick();
        end
        bif.Capture = 1'b0;
        tick();
        push_exp(S_COUNT, 32'd8,     "ovf_count");
        push_exp(S_OVF,   32'd1,     "ovf_flag");
        push_exp(S_STATE, ST_RECORD, "ovf_state");
        push_exp(S_DATA,  32'h0002,  "ovf_oldest");
        for (int k = 1; k < 8; k++) begin
            step_once(k, 32'(k + 2), $sformatf("ovf_step%0d", k));
        end
        step_once(0, 32'h0002, "ovf_wrap");

        // Clear with Step and Capture while full and overflowed
        bif.Clear = 1'b1; bif.Step = 1'b1; bif.Capture = 1'b1; bif.BusWires = 16'hFFFF;
        tick();
        bif.Clear = 1'b0; bif.Step = 1'b0; bif.Capture = 1'b0;
        check_cleared("clr_ovf");

        // Clear mid-record at Count=5 together with Step and Capture
        bif.Capture = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bif.BusWires = 16'h0100 + 16'(i);
            tick();
        end
        push_exp(S_COUNT, 32'd5, "rec5_count");
        bif.Clear = 1'b1; bif.Step = 1'b1; bif.BusWires = 16'hEEEE;
        tick();
        bif.Clear = 1'b0; bif.Step = 1'b0; bif.Capture = 1'b0;
        check_cleared("clr_rec5");

        // Reset during RECORD with Done, then resume with Capture held
        bif.Capture = 1'b1; bif.BusWires = 16'h0A0A; tick();
        bif.BusWires = 16'h0B0B; tick();
        push_exp(S_COUNT, 32'd2, "pre_rst_count");
        rst = 1'b1; bif.Done = 1'b1; bif.BusWires = 16'hDEAD;
        tick();
        push_exp(S_FROZEN, 32'd0,    "rst_frozen");
        push_exp(S_COUNT,  32'd0,    "rst_count");
        push_exp(S_STATE,  ST_ARMED, "rst_state");
        rst = 1'b0; bif.Done = 1'b0; bif.BusWires = 16'h5555;
        tick();
        push_exp(S_COUNT, 32'd1,     "resume_count");
        push_exp(S_STATE, ST_RECORD, "resume_state");
        bif.BusWires = 16'h6666;
        tick();
        bif.Capture = 1'b0;
        push_exp(S_COUNT, 32'd2,    "resume_count2");
        push_exp(S_DATA,  32'h5555, "resume_data");

        // Drain and report
        tick();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_trace_buffer.md
Name: bus_trace_buffer

Overview:
Reader-side companion to the processor's switch-driven DIN/Run input path. It records the processor bus (BusWires) into a small circular trace memory while an instruction runs, freezes the trace when Done asserts, and lets the user step through captured words with a push-button for HEX display. It sits beside proc in the board top level, fed by BusWires/Run/Done, with a KEY-derived step input.

Parameters:
WIDTH, 16, bus word width
DEPTH, 8, trace entries (power of 2)
AW, 3, log2(DEPTH)

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
BusWires  input  WIDTH  processor bus value to record
Capture  input  1  record enable (top level ties to Run)
Done  input  1  processor instruction-complete flag
Step  input  1  level from push-button (already inverted, 1 = pressed)
Clear  input  1  synchronous trace clear / re-arm
RdData  output  WIDTH  selected trace word, registered
RdIndex  output  AW  view position, 0 = oldest entry
Count  output  AW+1  valid entries, 0..DEPTH
Frozen  output  1  1 while in FROZEN state
Overflow  output  1  sticky: at least one entry overwritten

Behaviour:
- Reset (or Clear): state=ARMED, head=0, Count=0, RdIndex=0, Overflow=0, Frozen=0, RdData=0, step history register=0. Memory contents need not be cleared.
- FSM:
  - ARMED: if Capture=1, write BusWires, go RECORD. If Done=1 in the same cycle, write, then go FROZEN.
  - RECORD: write BusWires on every cycle with Capture=1. On Done=1, write that cycle's BusWires if Capture=1, then go FROZEN.
  - FROZEN: no writes. Leave only via Clear or Reset, both of which go to ARMED.
- Write: mem[(head+Count) mod DEPTH] <= BusWires.
  - Count<DEPTH: Count+1.
  - Count==DEPTH: overwrite oldest, head+1 mod DEPTH, Count unchanged, Overflow<=1.
- Step edge: pulse = Step & ~step_q; step_q <= Step every cycle.
  - Each pulse with Count>0: RdIndex <= (RdIndex==Count-1) ? 0 : RdIndex+1.
  - Pulse with Count==0 is ignored.
  - A held button gives exactly one advance.
- RdData: every cycle, RdData <= (Count==0) ? 0 : mem[(head+RdIndex) mod DEPTH], using pre-edge register values. RdData therefore lags any RdIndex/head/write change by one cycle.
- Read and write at the same address in the same cycle: RdData gets the old contents; the new word appears on the following cycle.
- Overwrite while viewing: RdIndex is kept, so it now refers to the new oldest+RdIndex.
- Precedence: Reset > Clear > write/step. Clear in the same cycle as Capture/Done/Step discards all of them.
- Capture and Step in the same cycle: both take effect. Wrap uses the pre-edge Count.
- Frozen = (state==FROZEN), registered.
- Overflow is cleared only by Reset or Clear.

Test Plan:
- Reset, then Capture=1 for 3 cycles with BusWires=0x1111, 0x2222, 0x3333; Done=1 on the third cycle. Required: Count=3, Frozen=1, RdData=0x1111. Three Step pulses give RdIndex 1, 2, 0 and RdData 0x2222, 0x3333, 0x1111 (each one cycle after the index change).
- Capture 10 words 0x0000..0x0009 with Done low. Required: Count=8, Overflow=1, RdIndex=0 shows 0x0002, RdIndex=7 shows 0x0009.
- In FROZEN, change BusWires and pulse Capture for 5 cycles. Required: Count and contents unchanged. Hold Step high for 20 cycles: RdIndex advances by exactly 1.
- Count=0, pulse Step. Required: RdIndex stays 0, RdData=0.
- Mid-RECORD (Count=5), assert Clear together with Step and Capture. Next cycle required: Count=0, RdIndex=0, Overflow=0, state ARMED, RdData=0.
- Assert Reset during RECORD with Done=1. Required: Frozen=0, Count=0. With Capture=1 held, recording resumes the cycle after Reset deasserts.
